// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - 16x16 unsigned shift-add multiplier with Load/Done handshake
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Load,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   P_hi,
    output logic [WIDTH-1:0]   P_lo,
    output logic               Ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]   r_acc_hi, w_acc_hi_nxt;
    logic [WIDTH-1:0]   r_acc_lo, w_acc_lo_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_p_hi, w_p_hi_nxt;
    logic [WIDTH-1:0]   r_p_lo, w_p_lo_nxt;
    logic               r_ovf, w_ovf_nxt;
    logic               r_done, w_done_nxt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;

    // The 17-bit sum keeps the adder carry; shifting {sum,acc_lo} right by one
    // drops that carry into acc_hi's MSB and the sum's LSB into acc_lo's MSB.
    assign w_sum     = {1'b0, r_acc_hi} + {1'b0, (r_acc_lo[0] ? r_mcand : {WIDTH{1'b0}})};
    assign w_step_hi = w_sum[WIDTH:1];
    assign w_step_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    always_comb begin
        w_state_nxt  = r_state;
        w_mcand_nxt  = r_mcand;
        w_acc_hi_nxt = r_acc_hi;
        w_acc_lo_nxt = r_acc_lo;
        w_cnt_nxt    = r_cnt;
        w_p_hi_nxt   = r_p_hi;
        w_p_lo_nxt   = r_p_lo;
        w_ovf_nxt    = r_ovf;
        w_done_nxt   = r_done;
        case (r_state)
            IDLE: begin
                if (Load) begin
                    w_mcand_nxt  = A;
                    w_acc_hi_nxt = '0;
                    w_acc_lo_nxt = B;
                    w_cnt_nxt    = '0;
                    w_done_nxt   = 1'b0;
                    w_state_nxt  = RUN;
                end
            end
            RUN: begin
                w_acc_hi_nxt = w_step_hi;
                w_acc_lo_nxt = w_step_lo;
                w_cnt_nxt    = r_cnt + 1'b1;
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_p_hi_nxt  = w_step_hi;
                    w_p_lo_nxt  = w_step_lo;
                    w_ovf_nxt   = (w_step_hi != '0);
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_mcand  <= w_mcand_nxt;
            r_acc_hi <= w_acc_hi_nxt;
            r_acc_lo <= w_acc_lo_nxt;
            r_cnt    <= w_cnt_nxt;
            r_p_hi   <= w_p_hi_nxt;
            r_p_lo   <= w_p_lo_nxt;
            r_ovf    <= w_ovf_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign Busy = (r_state == RUN);
    assign Done = r_done;
    assign P_hi = r_p_hi;
    assign P_lo = r_p_lo;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier against an arithmetic product model
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic        Load = 1'b0;
    logic        Busy, Done, Ovf;
    logic [15:0] P_hi, P_lo;

    int errors = 0;
    int checks = 0;

    seq_multiplier #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Load(Load),
        .Busy(Busy),
        .Done(Done),
        .P_hi(P_hi),
        .P_lo(P_lo),
        .Ovf (Ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_product(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wa, wb;
        wa = {16'h0, a};
        wb = {16'h0, b};
        return wa * wb;
    endfunction

    // Pulses Load for one edge, then counts edges until Done (bounded).
    // busy_bad counts cycles where Busy was not the complement of Done while waiting.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_bad);
        @(negedge clk);
        A = a; B = b; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        lat = 0;
        busy_bad = 0;
        while (Done !== 1'b1 && lat < 40) begin
            if (Busy !== 1'b1) busy_bad++;
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (Busy !== 1'b0) busy_bad++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; Load = 1'b1; A = 16'hABCD; B = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({Busy, Done, Ovf, P_hi, P_lo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b ovf=%0b p=%h_%h want all 0",
                     Busy, Done, Ovf, P_hi, P_lo);
        end
        rst = 1'b0; Load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_load_ignored got busy=%0b want 0", Busy);
        end
    endtask

    task automatic test_basic();
        int lat, bb;
        run_op(16'd3, 16'd5, lat, bb);
        checks++;
        if (lat != 16 || bb != 0) begin
            errors++;
            $display("FAIL basic_latency got lat=%0d busy_bad=%0d want lat=16 busy_bad=0", lat, bb);
        end
        checks++;
        if (P_hi !== 16'h0000 || P_lo !== 16'h000F || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL basic_product got %h_%h ovf=%0b want 0000_000f ovf=0", P_hi, P_lo, Ovf);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (Done !== 1'b1 || Busy !== 1'b0 || P_hi !== 16'h0 || P_lo !== 16'h000F) begin
                errors++;
                $display("FAIL basic_hold cycle %0d got done=%0b busy=%0b p=%h_%h want done=1 busy=0 p=0000_000f",
                         i, Done, Busy, P_hi, P_lo);
            end
        end
    endtask

    task automatic test_max();
        int lat, bb;
        run_op(16'hFFFF, 16'hFFFF, lat, bb);
        checks++;
        if (lat != 16 || P_hi !== 16'hFFFE || P_lo !== 16'h0001 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL max_operands got lat=%0d p=%h_%h ovf=%0b want lat=16 p=fffe_0001 ovf=1",
                     lat, P_hi, P_lo, Ovf);
        end
    endtask

    task automatic test_zero_stale();
        int lat, bb;
        int stale_bad;
        run_op(16'h1234, 16'h0010, lat, bb);
        checks++;
        if ({P_hi, P_lo} !== 32'h0001_2340 || Ovf !== 1'b1) begin
            errors++;
            $display("FAIL stale_first got %h_%h ovf=%0b want 0001_2340 ovf=1", P_hi, P_lo, Ovf);
        end
        @(negedge clk);
        A = 16'h1234; B = 16'h0000; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        stale_bad = 0;
        for (int k = 1; k <= 15; k++) begin
            if (Done !== 1'b0 || {P_hi, P_lo} !== 32'h0001_2340) stale_bad++;
            @(posedge clk);
            @(negedge clk);
        end
        if (Done !== 1'b0 || {P_hi, P_lo} !== 32'h0001_2340) stale_bad++;
        checks++;
        if (stale_bad != 0) begin
            errors++;
            $display("FAIL stale_during_run got %0d bad cycles want 0", stale_bad);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (Done !== 1'b1 || {P_hi, P_lo} !== 32'h0 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL zero_operand got done=%0b p=%h_%h ovf=%0b want done=1 p=0 ovf=0",
                     Done, P_hi, P_lo, Ovf);
        end
    endtask

    task automatic test_load_busy();
        int early;
        @(negedge clk);
        A = 16'd7; B = 16'd9; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        early = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 4) begin
                A = 16'hFFFF; B = 16'd2; Load = 1'b1;
            end else if (k == 5) begin
                Load = 1'b0;
            end
            if (k < 16 && Done !== 1'b0) early++;
        end
        checks++;
        if (early != 0 || Done !== 1'b1 || {P_hi, P_lo} !== 32'h0000_003F || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL load_while_busy got early=%0d done=%0b p=%h_%h ovf=%0b want early=0 done=1 p=0000_003f ovf=0",
                     early, Done, P_hi, P_lo, Ovf);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bb;
        @(negedge clk);
        A = 16'h00FF; B = 16'h0100; Load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        Load = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if ({Busy, Done, Ovf, P_hi, P_lo} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid got busy=%0b done=%0b ovf=%0b p=%h_%h want all 0",
                     Busy, Done, Ovf, P_hi, P_lo);
        end
        rst = 1'b0;
        run_op(16'd2, 16'd3, lat, bb);
        checks++;
        if (lat != 16 || {P_hi, P_lo} !== 32'd6 || Ovf !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got lat=%0d p=%h_%h ovf=%0b want lat=16 p=0000_0006 ovf=0",
                     lat, P_hi, P_lo, Ovf);
        end
    endtask

    task automatic test_continuous();
        logic want_done;
        @(negedge clk);
        A = 16'h8000; B = 16'd2; Load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            want_done = (i == 16 || i == 33);
            checks++;
            if (Done !== want_done || (Busy === 1'b1 && Done === 1'b1)) begin
                errors++;
                $display("FAIL continuous_done cycle %0d got done=%0b busy=%0b want done=%0b",
                         i, Done, Busy, want_done);
            end
            if (want_done) begin
                checks++;
                if (P_hi !== 16'h0001 || P_lo !== 16'h0000 || Ovf !== 1'b1) begin
                    errors++;
                    $display("FAIL continuous_product cycle %0d got %h_%h ovf=%0b want 0001_0000 ovf=1",
                             i, P_hi, P_lo, Ovf);
                end
            end
        end
        Load = 1'b0;
        repeat (20) @(posedge clk);
    endtask

    task automatic test_random_back_to_back();
        int lat, bb;
        logic [15:0] a, b;
        logic [31:0] exp_p;
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (n % 6 == 1) a = 16'($urandom_range(0, 255));
            if (n % 6 == 2) b = 16'($urandom_range(0, 3));
            exp_p = model_product(a, b);
            run_op(a, b, lat, bb);
            checks++;
            if (lat != 16 || bb != 0 || {P_hi, P_lo} !== exp_p || Ovf !== (exp_p[31:16] != 16'h0)) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h got lat=%0d busy_bad=%0d p=%h_%h ovf=%0b want lat=16 p=%h ovf=%0b",
                         n, a, b, lat, bb, P_hi, P_lo, Ovf, exp_p, (exp_p[31:16] != 16'h0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero_stale();
        test_load_busy();
        test_reset_mid();
        test_continuous();
        test_random_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Sequential 16x16 unsigned shift-add multiplier for the accumulator datapath: the multiply-side counterpart of the iterative divider. It uses the same Load/Done handshake, so the control unit can issue either operation through one sequencing scheme. The block captures two 16-bit operands on Load and iterates one multiplier bit per cycle. It then presents a 32-bit product split into high and low words with an overflow flag for 16-bit ACC write-back.

## Interface
- WIDTH, 16: operand width. Product is 2*WIDTH. The counter width is derived as clog2(WIDTH)+1.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- A  input  16  multiplicand, sampled only on an accepted Load.
- B  input  16  multiplier, sampled only on an accepted Load.
- Load  input  1  start request, level-sampled on each rising edge.
- Busy  output  1  high while iterating.
- Done  output  1  result-valid flag, held high until the next accepted Load or rst.
- P_hi  output  16  product bits [31:16].
- P_lo  output  16  product bits [15:0].
- Ovf  output  1  high when P_hi != 0, meaning the product does not fit in 16-bit ACC.

## Operation
- Reset: rst=1 at a rising edge forces the following, regardless of state or Load:
  - state=IDLE
  - Busy=0, Done=0, Ovf=0
  - P_hi=0, P_lo=0
  - internal registers=0
- Internal registers:
  - mcand: 16 b.
  - acc_hi: 16 b.
  - acc_lo: 16 b, initially the multiplier, then the low product.
  - cnt: 5 b.
- States: IDLE, RUN.
- IDLE with Load=1 (accepted Load):
  - mcand<=A, acc_hi<=0, acc_lo<=B, cnt<=0.
  - Done<=0, Busy<=1, state<=RUN.
- IDLE with Load=0: hold everything.
- RUN, each edge performs one step:
  - sum[16:0] = {1'b0,acc_hi} + (acc_lo[0] ? mcand : 0).
  - {acc_hi,acc_lo} <= {sum,acc_lo} >> 1, as a 33-bit right shift; the carry enters acc_hi[15].
  - cnt<=cnt+1.
- RUN step with cnt==15 (the 16th step):
  - P_hi/P_lo are loaded with the final shifted values.
  - Ovf<=(final hi != 0).
  - Done<=1, Busy<=0, state<=IDLE.
- Load while in RUN is ignored. Operands are not resampled and the iteration is unaffected.
- P_hi, P_lo and Ovf are written only at completion. During RUN they hold the previous result; only the Done=0 flag marks them stale.
- Arithmetic is unsigned only. The carry out of the 16-bit add must not be lost, because the 17-bit sum feeds the shift.
- Latency is fixed at 16 steps for all operands, including zero operands (no early exit).

## Timing
- Edge E0: Load accepted in IDLE. After E0: Busy=1, Done=0.
- Edges E1..E16: 16 RUN steps. After E16: Done=1, Busy=0, P/Ovf valid.
- Total latency is 16 cycles from the accepting edge to Done, with Load asserted for one cycle.
- Back-to-back operation: Load=1 at E17 (IDLE) is accepted, so throughput is one multiply per 17 cycles.
- Load held high continuously:
  - It re-triggers at every IDLE edge.
  - Done is high for exactly one cycle per operation (E16 to E17).
- rst and Load both high at the same edge: rst wins and Load is not accepted.
- rst asserted mid-RUN (any of E1..E16): the operation is aborted and all outputs read 0 after that edge. There is no Done pulse for the aborted operation.
- Busy and Done are never both 1. Busy=1 implies state=RUN.

## Test plan
- Basic multiply and hold:
  - A=3, B=5, Load pulse -> Busy high for 16 cycles, then Done=1, P_hi=0x0000, P_lo=0x000F, Ovf=0.
  - Done stays 1 and P stays unchanged for 10 idle cycles.
- Maximum operands:
  - A=0xFFFF, B=0xFFFF -> P_hi=0xFFFE, P_lo=0x0001, Ovf=1 after exactly 16 cycles.
  - This case checks carry propagation.
- Zero operand with stale-result check:
  - Run A=0x1234, B=0x0010 first -> P=0x0001_2340.
  - Then run A=0x1234, B=0 -> P_hi=0, P_lo=0, Ovf=0, still 16-cycle latency.
  - During the second run, P keeps 0x0001_2340 and Done=0.
- Load while busy:
  - Start A=7, B=9. At cycle 5 of RUN, pulse Load with A=0xFFFF, B=2 -> result 0x003F.
  - Done occurs at the original cycle 16 and the second Load is ignored.
- Reset mid-operation:
  - Start A=0x00FF, B=0x0100. Assert rst at cycle 8 of RUN -> Busy=0, Done=0, P=0, Ovf=0.
  - A subsequent Load with A=2, B=3 yields P_lo=6 after 16 cycles.
- Continuous Load:
  - Hold Load=1 with A=0x8000, B=2 for 40 cycles -> Done pulses one cycle wide at cycles 16 and 33.
  - Each result is P_hi=0x0001, P_lo=0x0000, Ovf=1.
